// File: rtl/dense_seq.sv
// Sequencer for one dense layer: per neuron it loads the bias, runs nb_input MAC steps and stores the result.
// Weight addresses advance by adding the neuron count on each MAC step, so no multiplier is needed.
module dense_seq #(
    parameter int MAX_IN   = 42,
    parameter int MAX_NEUR = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] nb_input,
    input  logic [4:0] nb_neurons,
    input  logic       stall,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       bias_ld,
    output logic [4:0] bias_addr,
    output logic       mac_en,
    output logic [9:0] w_addr,
    output logic [5:0] in_addr,
    output logic       out_wr,
    output logic [4:0] out_addr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BIAS  = 3'd1;
    localparam logic [2:0] S_MAC   = 3'd2;
    localparam logic [2:0] S_STORE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [5:0] MAX_IN_W   = 6'(MAX_IN);
    localparam logic [4:0] MAX_NEUR_W = 5'(MAX_NEUR);

    logic [2:0] state;
    logic [5:0] cfg_in;
    logic [4:0] cfg_neur;
    logic [4:0] n_q;
    logic [5:0] i_q;
    logic [9:0] w_q;
    logic       err_q;
    logic       cfg_ok;

    assign cfg_ok = (nb_input != 6'd0) && (nb_input <= MAX_IN_W) &&
                    (nb_neurons != 5'd0) && (nb_neurons <= MAX_NEUR_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cfg_in   <= '0;
            cfg_neur <= '0;
            n_q      <= '0;
            i_q      <= '0;
            w_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            cfg_in   <= nb_input;
                            cfg_neur <= nb_neurons;
                            n_q      <= '0;
                            i_q      <= '0;
                            w_q      <= '0;
                            state    <= S_BIAS;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_BIAS: begin
                    if (!stall) begin
                        i_q   <= '0;
                        state <= S_MAC;
                    end
                end
                S_MAC: begin
                    if (!stall) begin
                        if (i_q == cfg_in - 6'd1) begin
                            state <= S_STORE;
                        end else begin
                            i_q <= i_q + 6'd1;
                            w_q <= w_q + {5'd0, cfg_neur};
                        end
                    end
                end
                S_STORE: begin
                    if (!stall) begin
                        if (n_q == cfg_neur - 5'd1) begin
                            state <= S_DONE;
                        end else begin
                            // next neuron's first weight sits at index n
                            n_q   <= n_q + 5'd1;
                            w_q   <= {5'd0, n_q + 5'd1};
                            i_q   <= '0;
                            state <= S_BIAS;
                        end
                    end
                end
                S_DONE: begin
                    if (!stall) begin
                        n_q   <= '0;
                        i_q   <= '0;
                        w_q   <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy      = (state != S_IDLE);
    assign err       = err_q;
    assign bias_ld   = (state == S_BIAS)  && !stall;
    assign mac_en    = (state == S_MAC)   && !stall;
    assign out_wr    = (state == S_STORE) && !stall;
    assign done      = (state == S_DONE)  && !stall;
    assign bias_addr = n_q;
    assign out_addr  = n_q;
    assign in_addr   = i_q;
    assign w_addr    = w_q;

endmodule

// File: tb/tb_dense_seq.sv
// Randomized bench for dense_seq against a per-layer event list built from nested neuron/input loops.
module tb_dense_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] nb_input = '0;
    logic [4:0] nb_neurons = '0;
    logic       stall = 1'b0;
    logic       busy, done, err, bias_ld, mac_en, out_wr;
    logic [4:0] bias_addr, out_addr;
    logic [9:0] w_addr;
    logic [5:0] in_addr;

    int total = 0;
    int bad   = 0;

    localparam int K_BIAS = 0, K_MAC = 1, K_STORE = 2, K_DONE = 3;

    typedef struct {
        int kind;
        int a;
        int w;
        int i;
    } ev_t;

    dense_seq dut (
        .clk(clk), .rst(rst), .start(start), .nb_input(nb_input),
        .nb_neurons(nb_neurons), .stall(stall), .busy(busy), .done(done),
        .err(err), .bias_ld(bias_ld), .bias_addr(bias_addr), .mac_en(mac_en),
        .w_addr(w_addr), .in_addr(in_addr), .out_wr(out_wr), .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] all_out();
        return {busy, done, err, bias_ld, mac_en, out_wr, bias_addr, w_addr, in_addr, out_addr};
    endfunction

    // strobes {bias,mac,out,done,err} in [25:21], then only the fields that matter for the step kind
    function automatic logic [31:0] obs(input int kind);
        logic [31:0] v;
        v = '0;
        v[25:21] = {bias_ld, mac_en, out_wr, done, err};
        case (kind)
            K_BIAS:  v[20:16] = bias_addr;
            K_MAC:   begin v[15:6] = w_addr; v[5:0] = in_addr; end
            K_STORE: v[20:16] = out_addr;
            default: ;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] expv(input ev_t e, input bit st);
        logic [31:0] v;
        v = '0;
        if (!st) begin
            case (e.kind)
                K_BIAS:  v[25:21] = 5'b10000;
                K_MAC:   v[25:21] = 5'b01000;
                K_STORE: v[25:21] = 5'b00100;
                default: v[25:21] = 5'b00010;
            endcase
        end
        v[20:16] = 5'(e.a);
        v[15:6]  = 10'(e.w);
        v[5:0]   = 6'(e.i);
        return v;
    endfunction

    // smode: 0 none, 1 three stall cycles at MAC i=5, 2 random stall
    task automatic run(input int ni, input int nn, input int smode, input bit dup, input int abort_at);
        ev_t q[$];
        ev_t e;
        int  cyc, stalls, sc;
        bit  fin, st;
        for (int n = 0; n < nn; n++) begin
            e = '{K_BIAS, n, 0, 0};                q.push_back(e);
            for (int i = 0; i < ni; i++) begin
                e = '{K_MAC, 0, i * nn + n, i};    q.push_back(e);
            end
            e = '{K_STORE, n, 0, 0};               q.push_back(e);
        end
        e = '{K_DONE, 0, 0, 0};                    q.push_back(e);
        cyc = 0; stalls = 0; sc = 0; fin = 0;
        @(posedge clk); #1;
        start = 1'b1; nb_input = 6'(ni); nb_neurons = 5'(nn);
        @(posedge clk); #1;
        while (!fin && cyc < 3000) begin
            cyc++;
            if (cyc == abort_at) break;
            nb_input   = 6'($urandom);
            nb_neurons = 5'($urandom);
            start      = dup && (cyc == 10);
            case (smode)
                1:       st = (q[0].kind == K_MAC) && (q[0].i == 5) && (sc < 3);
                2:       st = ($urandom_range(0, 4) == 0);
                default: st = 1'b0;
            endcase
            stall = st;
            if (st) begin stalls++; sc++; end
            @(negedge clk);
            chk("busy", 32'(busy), 32'd1);
            chk("step", obs(q[0].kind), expv(q[0], st));
            if (!st) begin
                if (q[0].kind == K_DONE) fin = 1'b1;
                void'(q.pop_front());
            end
            if (!fin) begin @(posedge clk); #1; end
        end
        start = 1'b0;
        stall = 1'b0;
        if (abort_at > 0) return;
        if (!fin) chk("timeout", 32'd0, 32'd1);
        chk("run_len", 32'(cyc), 32'(nn * (ni + 2) + 1 + stalls));
        chk("mac_cnt_left", 32'(q.size()), 32'd0);
        @(posedge clk); @(negedge clk);
        chk("idle_after", all_out(), 32'd0);
    endtask

    task automatic bad_start(input int ni, input int nn);
        int errs;
        logic act;
        @(posedge clk); #1;
        start = 1'b1; nb_input = 6'(ni); nb_neurons = 5'(nn);
        @(posedge clk); #1;
        start = 1'b0;
        errs = 0; act = 1'b0;
        repeat (4) begin
            @(negedge clk);
            errs += int'(err);
            act |= busy | bias_ld | mac_en | out_wr | done;
            @(posedge clk); #1;
        end
        chk("err_pulses", 32'(errs), 32'd1);
        chk("err_quiet", 32'(act), 32'd0);
    endtask

    initial begin
        int dn;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", all_out(), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run(42, 24, 0, 0, 0);
        run(24, 1, 0, 0, 0);
        bad_start(0, 24);
        bad_start(43, 24);
        bad_start(10, 0);
        bad_start(10, 25);
        run(24, 1, 1, 0, 0);
        run(10, 5, 0, 1, 0);
        run(1, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++)
            run($urandom_range(1, 42), $urandom_range(1, 24), 2, 1'($urandom), 0);

        run(42, 24, 0, 0, 200);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_rst", all_out(), 32'd0);
        dn = 0;
        repeat (5) begin
            @(negedge clk);
            dn += int'(done) + int'(busy);
        end
        chk("abort_quiet", 32'(dn), 32'd0);
        run(24, 1, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dense_seq.md
DENSE_SEQ -- requirements
Module: dense_seq

Interface
REQ-001 Parameter MAX_IN, default 42, max inputs per layer.
REQ-002 Parameter MAX_NEUR, default 24, max neurons per layer.
REQ-003 Ports: clock and reset are decided; one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to run one dense layer; sampled only in IDLE.
REQ-007 nb_input  input  6  layer input count; latched with start.
REQ-008 nb_neurons  input  5  layer neuron count; latched with start.
REQ-009 stall  input  1  datapath not ready; freezes sequencing.
REQ-010 busy  output  1  high from the cycle after an accepted start through the DONE cycle.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  one-cycle pulse on a rejected start.
REQ-013 bias_ld  output  1  load accumulator with bias[bias_addr].
REQ-014 bias_addr  output  5  bias index = current neuron n.
REQ-015 mac_en  output  1  accumulate weight[w_addr] * in[in_addr].
REQ-016 w_addr  output  10  weight index = i*nb_neurons + n.
REQ-017 in_addr  output  6  input index i.
REQ-018 out_wr  output  1  write scaled/activated accumulator to out[out_addr].
REQ-019 out_addr  output  5  output index = n.

Function
REQ-020 FSM states SHALL be IDLE, BIAS, MAC, STORE and DONE.
REQ-021 In IDLE, a start with 1<=nb_input<=MAX_IN and 1<=nb_neurons<=MAX_NEUR SHALL latch the config, set n=0 and i=0, and move to BIAS on the next edge.
REQ-022 In IDLE, a start with a zero or out-of-range count SHALL pulse err for 1 cycle and remain in IDLE.
REQ-023 BIAS SHALL assert bias_ld with bias_addr=n for 1 cycle, then go to MAC with i=0.
REQ-024 MAC SHALL assert mac_en for nb_input cycles (i=0..nb_input-1), with in_addr=i and w_addr=i*nb_neurons+n.
REQ-025 After i=nb_input-1, the FSM SHALL go to STORE.
REQ-026 w_addr SHALL be generated incrementally: load n in BIAS, then add the latched nb_neurons per MAC step. No multiplier.
REQ-027 STORE SHALL assert out_wr with out_addr=n for 1 cycle.
REQ-028 From STORE, if n<nb_neurons-1 the FSM SHALL increment n and go to BIAS; otherwise it SHALL go to DONE.
REQ-029 DONE SHALL pulse done for 1 cycle and return to IDLE. A start is accepted again the following cycle.
REQ-030 Run length from the accepted-start edge to the done cycle SHALL be nb_neurons*(nb_input+2)+1 cycles when there is no stall.
REQ-031 While stall=1, state, counters and addresses SHALL hold, and bias_ld, mac_en, out_wr and done SHALL be 0.
REQ-032 A stalled step SHALL be issued exactly once, after stall falls.
REQ-033 Stall SHALL have no effect in IDLE.
REQ-034 A start while busy SHALL be ignored: no err, and the latched config is unchanged.
REQ-035 Changes to nb_input or nb_neurons during a run SHALL have no effect.
REQ-036 At most one of bias_ld, mac_en and out_wr SHALL be high in any cycle.
REQ-037 Address outputs SHALL be registered.
REQ-038 Addresses SHALL be 0 in IDLE.

Reset
REQ-039 On rst=1 at a clock edge: FSM to IDLE; counters and latched config to 0; busy, done, err, bias_ld, mac_en and out_wr to 0; all addresses to 0.
REQ-040 Reset SHALL take priority over start and stall, including mid-run, and SHALL abort the run without a done pulse.

Verification
REQ-041 Start with 42x24, no stall -> busy=1; done at cycle 1057 after start; 1008 mac_en, 24 bias_ld and 24 out_wr pulses; neuron 1 w_addr = 1,25,...,985; max w_addr = 1007.
REQ-042 Start with 24x1 -> w_addr = 0..23, out_addr=0; done at cycle 27.
REQ-043 Start with 0x24 or 43x24 -> err pulse 1 cycle; busy stays 0; no strobes.
REQ-044 Run 24x1 with stall=1 for 3 cycles at i=5 -> w_addr held at 5; mac_en=0 for those 3 cycles; done delayed 3 cycles; 24 total mac_en pulses.
REQ-045 rst=1 during MAC of a 42x24 run -> next cycle: IDLE with all outputs 0 and no done; a new start of 24x1 completes normally.
REQ-046 Second start pulsed mid-run with a different config -> ignored; the original run completes with the original addresses and timing.
